// File: rtl/glb_addr_gen.sv
// 2-D logical-address sequencer for one GLB tile transfer.
// Emits base + r*stride + c (row-major) with a valid/ready handshake toward the GLB port.
//
// state | meaning
// IDLE  | waiting for i_start; config inputs sampled on the start cycle
// RUN   | o_valid high; advance the address on each accepted handshake
// DONE  | one-cycle o_done pulse, o_busy still high, then back to IDLE
module glb_addr_gen #(
    parameter int BANK_NUM   = 27,
    parameter int BANK_DEPTH = 512,
    parameter int CNT_W      = 8,
    parameter int ADDR_W     = $clog2(BANK_NUM * BANK_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [1:0]        i_data_type,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [CNT_W-1:0]  i_rows,
    input  logic [CNT_W-1:0]  i_cols,
    input  logic [CNT_W-1:0]  i_stride,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_data_type,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_row_base;
    logic [CNT_W-1:0]  r_stride;
    logic [CNT_W-1:0]  r_cols_m1;
    logic [CNT_W-1:0]  r_col_left;
    logic [CNT_W-1:0]  r_row_left;
    logic [1:0]        r_data_type;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_hs;
    logic [ADDR_W-1:0] w_next_row_base;

    assign w_hs            = r_valid & i_ready;
    assign w_next_row_base = r_row_base + ADDR_W'(r_stride);

    // Row/column positions are down-counters: zero means the last column/row is current.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_row_base  <= '0;
            r_stride    <= '0;
            r_cols_m1   <= '0;
            r_col_left  <= '0;
            r_row_left  <= '0;
            r_data_type <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_data_type <= i_data_type;
                        r_stride    <= i_stride;
                        r_cols_m1   <= i_cols - CNT_W'(1);
                        r_busy      <= 1'b1;
                        if (i_rows == '0 || i_cols == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_addr     <= i_base;
                            r_row_base <= i_base;
                            r_col_left <= i_cols - CNT_W'(1);
                            r_row_left <= i_rows - CNT_W'(1);
                            r_valid    <= 1'b1;
                            r_state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        if (r_col_left != '0) begin
                            r_col_left <= r_col_left - CNT_W'(1);
                            r_addr     <= r_addr + ADDR_W'(1);
                        end else if (r_row_left != '0) begin
                            r_col_left <= r_cols_m1;
                            r_row_left <= r_row_left - CNT_W'(1);
                            r_row_base <= w_next_row_base;
                            r_addr     <= w_next_row_base;
                        end else begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_addr      = r_addr;
    assign o_data_type = r_data_type;
    assign o_valid     = r_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_glb_addr_gen.sv
// Directed testbench for glb_addr_gen: fixed tiles with hand-computed address sequences.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_glb_addr_gen;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_data_type;
    logic [13:0] i_base;
    logic [7:0]  i_rows;
    logic [7:0]  i_cols;
    logic [7:0]  i_stride;
    logic [13:0] o_addr;
    logic [1:0]  o_data_type;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    glb_addr_gen dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_data_type (i_data_type),
        .i_base      (i_base),
        .i_rows      (i_rows),
        .i_cols      (i_cols),
        .i_stride    (i_stride),
        .o_addr      (o_addr),
        .o_data_type (o_data_type),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // Caller is on a falling edge; returns on the falling edge of the first cycle after start.
    task automatic start_xfer(input logic [1:0] t, input logic [13:0] b,
                              input logic [7:0] r, input logic [7:0] c, input logic [7:0] s);
        i_start     = 1'b1;
        i_data_type = t;
        i_base      = b;
        i_rows      = r;
        i_cols      = c;
        i_stride    = s;
        @(negedge i_clk);
        i_start     = 1'b0;
        i_base      = 14'd0;
        i_rows      = 8'd0;
        i_cols      = 8'd0;
        i_stride    = 8'd0;
        i_data_type = 2'd0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b0;
        i_data_type = 2'd0; i_base = 14'd0; i_rows = 8'd0; i_cols = 8'd0; i_stride = 8'd0;
        repeat (3) @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", o_valid); end
        checks++; if (o_addr !== 14'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", o_addr); end
        checks++; if (o_data_type !== 2'd0) begin errors++; $display("FAIL reset_type got %0d exp 0", o_data_type); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", o_done); end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_basic;
        int exp_a[6] = '{100, 101, 102, 110, 111, 112};
        i_ready = 1'b1;
        start_xfer(2'd2, 14'd100, 8'd2, 8'd3, 8'd10);
        for (int k = 0; k < 6; k++) begin
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %0b exp 1", k, o_valid); end
            checks++; if (o_addr !== 14'(exp_a[k])) begin errors++; $display("FAIL basic_addr[%0d] got %0d exp %0d", k, o_addr, exp_a[k]); end
            checks++; if (o_data_type !== 2'd2) begin errors++; $display("FAIL basic_type[%0d] got %0d exp 2", k, o_data_type); end
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d] got %0b exp 1", k, o_busy); end
            @(negedge i_clk);
        end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL basic_done got %0b exp 1", o_done); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_end got %0b exp 0", o_valid); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got %0b exp 1", o_busy); end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b exp 0", o_done); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got %0b exp 0", o_busy); end
        checks++; if (o_data_type !== 2'd2) begin errors++; $display("FAIL basic_type_hold got %0d exp 2", o_data_type); end
    endtask

    task automatic test_backpressure;
        int exp_a[6] = '{100, 101, 102, 110, 111, 112};
        logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int hs = 0;
        int cyc = 0;
        i_ready = 1'b0;
        start_xfer(2'd2, 14'd100, 8'd2, 8'd3, 8'd10);
        while (o_valid === 1'b1 && cyc < 60) begin
            i_ready = pat[cyc % 4];
            if (hs < 6) begin
                checks++; if (o_addr !== 14'(exp_a[hs])) begin errors++; $display("FAIL bp_addr[%0d] got %0d exp %0d", hs, o_addr, exp_a[hs]); end
            end
            if (i_ready) hs++;
            cyc++;
            @(negedge i_clk);
        end
        i_ready = 1'b0;
        checks++; if (hs !== 6) begin errors++; $display("FAIL bp_handshakes got %0d exp 6", hs); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL bp_done got %0b exp 1", o_done); end
        @(negedge i_clk);
    endtask

    task automatic test_zero;
        i_ready = 1'b1;
        start_xfer(2'd1, 14'd40, 8'd0, 8'd3, 8'd1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL zero_rows_valid got %0b exp 0", o_valid); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL zero_rows_done got %0b exp 1", o_done); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL zero_rows_busy got %0b exp 1", o_busy); end
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_valid !== 1'b0) begin
            errors++; $display("FAIL zero_rows_idle got busy %0b done %0b valid %0b exp 000", o_busy, o_done, o_valid); end
        start_xfer(2'd3, 14'd40, 8'd4, 8'd0, 8'd1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL zero_cols_valid got %0b exp 0", o_valid); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL zero_cols_done got %0b exp 1", o_done); end
        checks++; if (o_data_type !== 2'd3) begin errors++; $display("FAIL zero_cols_type got %0d exp 3", o_data_type); end
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++; $display("FAIL zero_cols_idle got busy %0b valid %0b exp 00", o_busy, o_valid); end
    endtask

    task automatic test_start_ignored;
        i_ready = 1'b0;
        start_xfer(2'd1, 14'd50, 8'd1, 8'd3, 8'd0);
        i_start = 1'b1; i_base = 14'd900; i_rows = 8'd5; i_cols = 8'd5; i_data_type = 2'd3;
        @(negedge i_clk);
        i_start = 1'b0;
        checks++; if (o_addr !== 14'd50) begin errors++; $display("FAIL ign_addr got %0d exp 50", o_addr); end
        checks++; if (o_data_type !== 2'd1) begin errors++; $display("FAIL ign_type got %0d exp 1", o_data_type); end
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_addr !== 14'(50 + k) || o_valid !== 1'b1) begin
                errors++; $display("FAIL ign_seq[%0d] got %0d valid %0b exp %0d valid 1", k, o_addr, o_valid, 50 + k); end
            @(negedge i_clk);
        end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL ign_done got %0b exp 1", o_done); end
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL ign_done_start got valid %0b busy %0b exp 00", o_valid, o_busy); end
        @(negedge i_clk);
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL ign_no_second got valid %0b busy %0b exp 00", o_valid, o_busy); end
        i_base = 14'd0; i_rows = 8'd0; i_cols = 8'd0; i_data_type = 2'd0;
    endtask

    task automatic test_wrap;
        int exp_a[4] = '{16382, 16383, 0, 1};
        i_ready = 1'b1;
        start_xfer(2'd3, 14'd16382, 8'd1, 8'd4, 8'd0);
        for (int k = 0; k < 4; k++) begin
            checks++; if (o_addr !== 14'(exp_a[k]) || o_valid !== 1'b1) begin
                errors++; $display("FAIL wrap_addr[%0d] got %0d valid %0b exp %0d valid 1", k, o_addr, o_valid, exp_a[k]); end
            @(negedge i_clk);
        end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL wrap_done got %0b exp 1", o_done); end
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid;
        i_ready = 1'b1;
        start_xfer(2'd1, 14'd200, 8'd2, 8'd3, 8'd5);
        checks++; if (o_addr !== 14'd200) begin errors++; $display("FAIL rmid_a0 got %0d exp 200", o_addr); end
        @(negedge i_clk);
        checks++; if (o_addr !== 14'd201) begin errors++; $display("FAIL rmid_a1 got %0d exp 201", o_addr); end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL rmid_abort got valid %0b busy %0b done %0b exp 000", o_valid, o_busy, o_done); end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rmid_no_done got %0b exp 0", o_done); end
        start_xfer(2'd2, 14'd300, 8'd1, 8'd2, 8'd0);
        checks++; if (o_addr !== 14'd300 || o_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_restart0 got %0d valid %0b exp 300 valid 1", o_addr, o_valid); end
        @(negedge i_clk);
        checks++; if (o_addr !== 14'd301) begin errors++; $display("FAIL rmid_restart1 got %0d exp 301", o_addr); end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL rmid_restart_done got %0b exp 1", o_done); end
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back;
        int hs = 0;
        int dones = 0;
        i_ready = 1'b1;
        start_xfer(2'd1, 14'd7, 8'd1, 8'd1, 8'd0);
        checks++; if (o_addr !== 14'd7 || o_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_a0 got %0d valid %0b exp 7 valid 1", o_addr, o_valid); end
        if (o_valid) hs++;
        @(negedge i_clk);
        checks++; if (o_done !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_done0 got done %0b valid %0b exp done 1 valid 0", o_done, o_valid); end
        if (o_done) dones++;
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy %0b exp 0", o_busy); end
        start_xfer(2'd3, 14'd8, 8'd1, 8'd1, 8'd0);
        checks++; if (o_addr !== 14'd8 || o_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_a1 got %0d valid %0b exp 8 valid 1", o_addr, o_valid); end
        if (o_valid) hs++;
        @(negedge i_clk);
        if (o_valid) hs++;
        if (o_done) dones++;
        @(negedge i_clk);
        if (o_valid) hs++;
        if (o_done) dones++;
        checks++; if (hs !== 2) begin errors++; $display("FAIL b2b_handshakes got %0d exp 2", hs); end
        checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_dones got %0d exp 2", dones); end
    endtask

    initial begin
        @(negedge i_clk);
        test_reset;
        test_basic;
        test_backpressure;
        test_zero;
        test_start_ignored;
        test_wrap;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
